// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small write FIFO: start bit, DATA_W data bits LSB first, STOP_BITS stop bits.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trmt,
  input  logic [DATA_W-1:0] tx_data,
  output logic              TX,
  output logic              tx_full,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_ovf
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = 4;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DATA_W - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, ovf_q;

  state_e            state_q;
  logic [BW-1:0]     baud_q;
  logic [NW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_q, busy_q, done_q;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  logic              push, pop, baud_end, frame_end;
  logic [DATA_W-1:0] head;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    baud_end  = (baud_q == BAUD_LAST);
    frame_end = (state_q == STOP) && baud_end && (bit_q == STOP_LAST);
    push      = trmt && !full_q;
    pop       = (count_q != '0) && ((state_q == IDLE) || frame_end);
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      ovf_q   <= trmt && full_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
        end
        START: begin
          if (baud_end) begin
            state_q <= DATA;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
              bit_q   <= '0;
`endif
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + NW'(1);
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            state_q <= STOP;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              done_q  <= 1'b1;
              bit_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + NW'(1);
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
      // A pop (from IDLE or at the last stop edge) overrides the case above to start the next frame
      if (pop) begin
        state_q <= START;
        baud_q  <= '0;
        shift_q <= head;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
        par_q   <= ^head;
`endif
      end
    end
  end

  assign TX      = tx_q;
  assign tx_full = full_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign tx_ovf  = ovf_q;

endmodule
